// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite definitions for the SRAM subordinate.
// Holds the bus encodings (htrans, hburst, hsize, hresp), the slave FSM
// state type and the byte-lane strobe helper used by the write path.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_W64   = 3'b011,
    HSIZE_W128  = 3'b100,
    HSIZE_W256  = 3'b101,
    HSIZE_W512  = 3'b110,
    HSIZE_W1024 = 3'b111
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slave_state_t;

  // Little-endian lane mask for a transfer of the given size at addr[1:0].
  // Unsupported sizes select no lanes.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      3'b000:  strb = 4'b0001 << addr;
      3'b001:  strb = addr[1] ? 4'b1100 : 4'b0011;
      3'b010:  strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM subordinate.
// master modport: drives address/control/write data and the bus-level HREADY.
// slave modport : drives HRDATA, HREADYOUT and HRESP, samples everything else.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave_mem.sv
// ahb_sram_mem: 32-bit wide synchronous SRAM of WORDS words.
// Ports: clk, rst_n (sync active-low, clears only the read register),
//        we/waddr/wstrb/wdata (byte-masked write), re/raddr (registered read),
//        rdata (read register output).
// A read of the word being written on the same edge returns the merged
// post-write value.
module ahb_sram_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] merged;

  // Write-through bypass: overlay the lanes being written this edge.
  always_comb begin
    merged = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= merged;
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite subordinate backed by an on-chip SRAM, with
// WAIT_STATES wait cycles on every OKAY transfer and a two-cycle ERROR response
// for out-of-range, oversized or misaligned accesses.
// Ports: HCLK (bus clock), HRESETn (sync active-low reset),
//        bus (slave modport: samples address/control/HWDATA/HREADY,
//        drives HRDATA, HREADYOUT, HRESP).
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_BYTES   = 4096,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  slave_state_t  state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          hreadyout;
  hresp_t        hresp;

  logic [31:0]   offset;
  logic          capture, cap_err;
  logic [AW-1:0] cap_word;

  logic          pend_valid, pend_write;
  logic [AW-1:0] pend_addr;
  logic [3:0]    pend_strb;

  logic          mem_we, rd_en, rd_zero;
  logic [AW-1:0] rd_addr;
  logic [31:0]   mem_rdata;
  logic          unused_bits;

  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

  assign offset   = bus.HADDR - BASE_ADDR;
  assign capture  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign cap_word = offset[AW+1:2];

  // An address below BASE_ADDR wraps to a huge offset and is caught by the range test.
  always_comb begin
    cap_err = (offset >= 32'(MEM_BYTES))
           || (bus.HSIZE > 3'b010)
           || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
           || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ERR2 is a completing cycle, so it accepts a new address phase like IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (capture) begin
          if (cap_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ST_IDLE;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Address-phase registers only advance when the current data phase completes,
  // since the bus holds the next address phase while HREADYOUT is low.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_addr  <= '0;
      pend_strb  <= '0;
    end else if (hreadyout) begin
      pend_valid <= capture && !cap_err;
      pend_write <= bus.HWRITE;
      pend_addr  <= cap_word;
      pend_strb  <= byte_strobe(bus.HSIZE, bus.HADDR[1:0]);
    end
  end

  // Writes commit on the edge that ends the completing data-phase cycle; gating
  // with HRESETn drops a write that coincides with reset.
  assign mem_we = pend_valid && pend_write && hreadyout && HRESETn;

  // With no wait states the read must be launched from the address phase so the
  // data is ready one cycle later; otherwise it is launched on the last wait cycle
  // so HRDATA only changes when the read actually completes.
  assign rd_en   = (WAIT_STATES == 0) ? (capture && !cap_err && !bus.HWRITE)
                                      : ((state == ST_WAIT) && (cnt == 4'd1) && !pend_write);
  assign rd_addr = (WAIT_STATES == 0) ? cap_word : pend_addr;

  // Errored reads force HRDATA to zero until the next good read completes.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)                                 rd_zero <= 1'b0;
    else if (rd_en)                               rd_zero <= 1'b0;
    else if ((state == ST_ERR1) && !pend_write)   rd_zero <= 1'b1;
  end

  ahb_sram_mem #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .we    (mem_we),
    .waddr (pend_addr),
    .wstrb (pend_strb),
    .wdata (bus.HWDATA),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  assign bus.HRDATA    = rd_zero ? 32'h0 : mem_rdata;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed self-checking bench for ahb_lite_sram_slave. Three instances share the
// stimulus (WAIT_STATES = 0, 2, 3); 'sel' picks which one is addressed and observed.
module tb_ahb_lite_sram_slave;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  int          sel;
  logic        hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;

  logic [31:0] hrdata_o;
  logic        hready_o, hresp_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave_if b0 ();
  ahb_lite_sram_slave_if b2 ();
  ahb_lite_sram_slave_if b3 ();

  assign b0.HSEL = hsel && (sel == 0);
  assign b0.HADDR = haddr;
  assign b0.HTRANS = htrans;
  assign b0.HWRITE = hwrite;
  assign b0.HSIZE = hsize;
  assign b0.HBURST = 3'b000;
  assign b0.HPROT = 4'b0011;
  assign b0.HMASTLOCK = 1'b0;
  assign b0.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;

  assign b2.HSEL = hsel && (sel == 2);
  assign b2.HADDR = haddr;
  assign b2.HTRANS = htrans;
  assign b2.HWRITE = hwrite;
  assign b2.HSIZE = hsize;
  assign b2.HBURST = 3'b000;
  assign b2.HPROT = 4'b0011;
  assign b2.HMASTLOCK = 1'b0;
  assign b2.HWDATA = hwdata;
  assign b2.HREADY = b2.HREADYOUT;

  assign b3.HSEL = hsel && (sel == 3);
  assign b3.HADDR = haddr;
  assign b3.HTRANS = htrans;
  assign b3.HWRITE = hwrite;
  assign b3.HSIZE = hsize;
  assign b3.HBURST = 3'b000;
  assign b3.HPROT = 4'b0011;
  assign b3.HMASTLOCK = 1'b0;
  assign b3.HWDATA = hwdata;
  assign b3.HREADY = b3.HREADYOUT;

  ahb_lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(b0));
  ahb_lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(b2));
  ahb_lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(b3));

  always_comb begin
    case (sel)
      0:       begin hrdata_o = b0.HRDATA; hready_o = b0.HREADYOUT; hresp_o = b0.HRESP; end
      2:       begin hrdata_o = b2.HRDATA; hready_o = b2.HREADYOUT; hresp_o = b2.HRESP; end
      default: begin hrdata_o = b3.HRDATA; hready_o = b3.HREADYOUT; hresp_o = b3.HRESP; end
    endcase
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = tr;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (hready_o !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (hready_o !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: HREADYOUT=%b after %0d cycles, required 1", name, hready_o, n);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_phase(a, 1'b1, sz, HTRANS_NONSEQ);
    cyc();
    hwdata = d;
    bus_idle();
    wait_ready("write");
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] d, output logic r);
    addr_phase(a, 1'b0, sz, HTRANS_NONSEQ);
    cyc();
    bus_idle();
    wait_ready("read");
    d = hrdata_o;
    r = hresp_o;
  endtask

  task automatic test_reset();
    int sels[3];
    sels = '{0, 2, 3};
    HRESETn = 1'b0;
    hwdata  = 32'h0;
    haddr   = 32'h0;
    hwrite  = 1'b0;
    hsize   = 3'b010;
    bus_idle();
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      #1;
      compared++;
      if (hready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hreadyout[%0d]: got %b want 1", sel, hready_o); end
      compared++;
      if (hresp_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hresp[%0d]: got %b want 0", sel, hresp_o); end
      compared++;
      if (hrdata_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hrdata[%0d]: got %h want 0", sel, hrdata_o); end
    end
    HRESETn = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    sel = 0;
    addr_phase(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    hwdata = 32'hDEADBEEF;
    compared++;
    if (hready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_write_ready: got %b want 1", hready_o); end
    addr_phase(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    bus_idle();
    compared++;
    if (hready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_read_ready: got %b want 1", hready_o); end
    compared++;
    if (hresp_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_read_resp: got %b want 0", hresp_o); end
    compared++;
    if (hrdata_o !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL b2b_read_data: got %h want deadbeef", hrdata_o); end
    cyc();
  endtask

  task automatic test_wait_states();
    sel = 2;
    do_write(32'h20, HSIZE_WORD, 32'h12345678);
    addr_phase(32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    bus_idle();
    compared++;
    if (hready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ws_stall1: got %b want 0", hready_o); end
    compared++;
    if (hresp_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ws_stall1_resp: got %b want 0", hresp_o); end
    cyc();
    compared++;
    if (hready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ws_stall2: got %b want 0", hready_o); end
    cyc();
    compared++;
    if (hready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ws_done: got %b want 1", hready_o); end
    compared++;
    if (hrdata_o !== 32'h12345678) begin mismatched++; $display("[TB] FAIL ws_data: got %h want 12345678", hrdata_o); end
    cyc();
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic        r;
    sel = 0;
    do_write(32'h40, HSIZE_WORD, 32'h0);
    do_write(32'h41, HSIZE_BYTE, 32'h0000AA00);
    do_write(32'h42, HSIZE_HALF, 32'h55660000);
    do_read(32'h40, HSIZE_WORD, d, r);
    compared++;
    if (d !== 32'h5566AA00) begin mismatched++; $display("[TB] FAIL lanes_word: got %h want 5566aa00", d); end
    compared++;
    if (r !== 1'b0) begin mismatched++; $display("[TB] FAIL lanes_resp: got %b want 0", r); end
    do_read(32'h41, HSIZE_BYTE, d, r);
    compared++;
    if (d !== 32'h5566AA00) begin mismatched++; $display("[TB] FAIL lanes_byte_read: got %h want 5566aa00", d); end
    cyc();
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        r;
    sel = 0;
    do_write(32'h00, HSIZE_WORD, 32'h0BADF00D);
    addr_phase(32'h1001, 1'b0, HSIZE_BYTE, HTRANS_NONSEQ);
    cyc();
    bus_idle();
    compared++;
    if (hready_o !== 1'b0 || hresp_o !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_err1: got ready=%b resp=%b want 0/1", hready_o, hresp_o); end
    cyc();
    compared++;
    if (hready_o !== 1'b1 || hresp_o !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_err2: got ready=%b resp=%b want 1/1", hready_o, hresp_o); end
    compared++;
    if (hrdata_o !== 32'h0) begin mismatched++; $display("[TB] FAIL oor_data: got %h want 0", hrdata_o); end
    addr_phase(32'h02, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    bus_idle();
    compared++;
    if (hready_o !== 1'b0 || hresp_o !== 1'b1) begin mismatched++; $display("[TB] FAIL misalign_err1: got ready=%b resp=%b want 0/1", hready_o, hresp_o); end
    cyc();
    compared++;
    if (hready_o !== 1'b1 || hresp_o !== 1'b1) begin mismatched++; $display("[TB] FAIL misalign_err2: got ready=%b resp=%b want 1/1", hready_o, hresp_o); end
    compared++;
    if (hrdata_o !== 32'h0) begin mismatched++; $display("[TB] FAIL misalign_data: got %h want 0", hrdata_o); end
    do_write(32'h1000, HSIZE_WORD, 32'hFFFFFFFF);
    compared++;
    if (hresp_o !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_write_resp: got %b want 1", hresp_o); end
    do_write(32'h02, HSIZE_WORD, 32'hFFFFFFFF);
    compared++;
    if (hresp_o !== 1'b1) begin mismatched++; $display("[TB] FAIL misalign_write_resp: got %b want 1", hresp_o); end
    do_read(32'h04, 3'b011, d, r);
    compared++;
    if (r !== 1'b1 || d !== 32'h0) begin mismatched++; $display("[TB] FAIL size_err: got resp=%b data=%h want 1/0", r, d); end
    do_read(32'h00, HSIZE_WORD, d, r);
    compared++;
    if (r !== 1'b0 || d !== 32'h0BADF00D) begin mismatched++; $display("[TB] FAIL mem_unchanged: got resp=%b data=%h want 0/0badf00d", r, d); end
    do_write(32'hFFC, HSIZE_WORD, 32'h01020304);
    do_read(32'hFFF, HSIZE_BYTE, d, r);
    compared++;
    if (r !== 1'b0 || d !== 32'h01020304) begin mismatched++; $display("[TB] FAIL top_byte: got resp=%b data=%h want 0/01020304", r, d); end
    cyc();
  endtask

  task automatic test_bypass_busy();
    sel = 0;
    do_write(32'h80, HSIZE_WORD, 32'h0);
    addr_phase(32'h80, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    hwdata = 32'hCAFEF00D;
    addr_phase(32'h80, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    compared++;
    if (hrdata_o !== 32'hCAFEF00D || hresp_o !== 1'b0) begin mismatched++; $display("[TB] FAIL bypass: got data=%h resp=%b want cafef00d/0", hrdata_o, hresp_o); end
    addr_phase(32'h84, 1'b0, HSIZE_WORD, HTRANS_BUSY);
    cyc();
    bus_idle();
    compared++;
    if (hready_o !== 1'b1 || hresp_o !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_okay: got ready=%b resp=%b want 1/0", hready_o, hresp_o); end
    compared++;
    if (hrdata_o !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL busy_hold: got %h want cafef00d", hrdata_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        r;
    sel = 3;
    do_write(32'h30, HSIZE_WORD, 32'h0);
    do_write(32'h34, HSIZE_WORD, 32'h77777777);
    do_read(32'h34, HSIZE_WORD, d, r);
    compared++;
    if (d !== 32'h77777777) begin mismatched++; $display("[TB] FAIL ws3_read: got %h want 77777777", d); end
    addr_phase(32'h30, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    hwdata = 32'h11111111;
    bus_idle();
    compared++;
    if (hready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ws3_wait1: got %b want 0", hready_o); end
    cyc();
    HRESETn = 1'b0;
    cyc();
    compared++;
    if (hready_o !== 1'b1 || hresp_o !== 1'b0 || hrdata_o !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got ready=%b resp=%b data=%h want 1/0/0", hready_o, hresp_o, hrdata_o);
    end
    HRESETn = 1'b1;
    cyc();
    do_read(32'h30, HSIZE_WORD, d, r);
    compared++;
    if (d !== 32'h0 || r !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_nowrite: got data=%h resp=%b want 0/0", d, r); end
    cyc();
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_bypass_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
